inst_mem_loader: RTL and testbench

//  Boot-time writer for the 4KB byte-addressed instruction memory. Accepts a byte stream
//  (length header, payload, XOR checksum), packs payload little-endian into 32-bit words
//  and drives a word write port with byte enables. Holds the CPU in reset while loading.

---
 rtl/inst_mem_loader_pkg.sv | 40 ++++
 rtl/inst_mem_loader_packer.sv | 76 +++++++
 rtl/inst_mem_loader.sv | 176 +++++++++++++++++
 tb/tb_inst_mem_loader.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// ============================================================================
// Module   : inst_mem_loader_pkg
// Brief    : Shared state encodings, error codes and defaults for the loader.
// Revision : 1.0
// ============================================================================
`default_nettype none

package inst_mem_loader_pkg;

  localparam int DEPTH_DEFAULT   = 4096;
  localparam int ADDR_W_DEFAULT  = 12;
  localparam int TIMEOUT_DEFAULT = 1000000;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] ST_LEN_LO = 3'd1;
  localparam logic [STATE_W-1:0] ST_LEN_HI = 3'd2;
  localparam logic [STATE_W-1:0] ST_DATA   = 3'd3;
  localparam logic [STATE_W-1:0] ST_CHECK  = 3'd4;
  localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;
  localparam logic [STATE_W-1:0] ST_ERR    = 3'd6;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_BAD_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHECKSUM = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_load_state(input logic [STATE_W-1:0] s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
  endfunction

  function automatic logic is_start_state(input logic [STATE_W-1:0] s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/inst_mem_loader_packer.sv
// ============================================================================
// Module   : inst_mem_loader_packer
// Brief    : Packs payload bytes little-endian into words and drives the write port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_mem_loader_packer
  import inst_mem_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [ADDR_W-1:0] byte_idx,
  input  logic [7:0]        data_byte,
  input  logic              last,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be
);

  logic [31:0] r_buf_data;
  logic [3:0]  r_buf_be;
  logic [1:0]  w_lane;
  logic [31:0] w_merged_data;
  logic [3:0]  w_merged_be;
  logic        w_emit;

  assign w_lane = byte_idx[1:0];
  assign w_emit = push && ((w_lane == 2'd3) || last);

  always_comb begin
    w_merged_data = r_buf_data;
    w_merged_be   = r_buf_be;
    w_merged_data[{w_lane, 3'b000} +: 8] = data_byte;
    w_merged_be[w_lane] = 1'b1;
  end

  // The emitting byte goes straight into the write register, so the buffer
  // is free again on the same edge and the stream never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_data <= '0;
      r_buf_be   <= '0;
    end else if (clear || w_emit) begin
      r_buf_data <= '0;
      r_buf_be   <= '0;
    end else if (push) begin
      r_buf_data <= w_merged_data;
      r_buf_be   <= w_merged_be;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_be   <= '0;
    end else begin
      wr_en <= w_emit;
      if (w_emit) begin
        wr_addr <= {byte_idx[ADDR_W-1:2], 2'b00};
        wr_data <= w_merged_data;
        wr_be   <= w_merged_be;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/inst_mem_loader.sv
// ============================================================================
// Module   : inst_mem_loader
// Brief    : Boot-time loader: length header, payload, XOR checksum -> word writes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_be,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   bytes_loaded
);

  localparam int                 TCNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);
  localparam logic [16:0]        DEPTH_MAX = 17'(DEPTH);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [15:0]        r_len;
  logic [7:0]         r_xsum;
  logic [TCNT_W-1:0]  r_tcnt;
  logic [1:0]         w_fail_code;
  logic               w_accept;
  logic               w_start_ok;
  logic               w_timeout;
  logic [15:0]        w_len_full;
  logic               w_len_bad;
  logic               w_last_byte;
  logic               w_push;

  assign w_accept    = in_valid && in_ready;
  assign w_start_ok  = start && is_start_state(r_state);
  assign w_timeout   = is_load_state(r_state) && !w_accept && (r_tcnt == TCNT_LAST);
  assign w_len_full  = {in_byte, r_len[7:0]};
  assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > DEPTH_MAX);
  assign w_last_byte = ((16'(bytes_loaded) + 16'd1) == r_len);
  assign w_push      = w_accept && (r_state == ST_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail_code = ERR_NONE;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) w_state_nxt = ST_LEN_LO;
      end
      ST_LEN_LO: begin
        if (w_accept) w_state_nxt = ST_LEN_HI;
      end
      ST_LEN_HI: begin
        if (w_accept) begin
          if (w_len_bad) begin
            w_state_nxt = ST_ERR;
            w_fail_code = ERR_BAD_LEN;
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (w_accept && w_last_byte) w_state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_accept) begin
          if (in_byte == r_xsum) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_ERR;
            w_fail_code = ERR_CHECKSUM;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Timeout only fires on a cycle without an accepted byte, so it never
    // competes with the transitions above.
    if (w_timeout) begin
      w_state_nxt = ST_ERR;
      w_fail_code = ERR_TIMEOUT;
    end
  end

  always_comb begin
    in_ready = 1'b0;
    cpu_hold = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (r_state)
      ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
      end
      ST_DONE: done = 1'b1;
      ST_ERR: begin
        err      = 1'b1;
        cpu_hold = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len        <= '0;
      r_xsum       <= '0;
      bytes_loaded <= '0;
      err_code     <= ERR_NONE;
    end else if (w_start_ok) begin
      r_len        <= '0;
      r_xsum       <= '0;
      bytes_loaded <= '0;
      err_code     <= ERR_NONE;
    end else begin
      if (w_accept && (r_state == ST_LEN_LO)) r_len[7:0]  <= in_byte;
      if (w_accept && (r_state == ST_LEN_HI)) r_len[15:8] <= in_byte;
      if (w_push) begin
        r_xsum       <= r_xsum ^ in_byte;
        bytes_loaded <= bytes_loaded + 1'b1;
      end
      if ((w_state_nxt == ST_ERR) && (r_state != ST_ERR)) err_code <= w_fail_code;
    end
  end

  // Counts consecutive idle cycles inside one load state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (w_accept || (w_state_nxt != r_state) || !is_load_state(r_state)) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + 1'b1;
    end
  end

  inst_mem_loader_packer #(
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (w_start_ok),
    .push      (w_push),
    .byte_idx  (bytes_loaded[ADDR_W-1:0]),
    .data_byte (in_byte),
    .last      (w_last_byte),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_be     (wr_be)
  );

endmodule

`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
// ============================================================================
// Module   : tb_inst_mem_loader
// Brief    : Scoreboard bench for inst_mem_loader with a byte-stream reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_inst_mem_loader;

  localparam int DEPTH  = 4096;
  localparam int ADDR_W = 12;
  localparam int TO     = 16;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    logic [3:0]        be;
  } wr_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [3:0]        wr_be;
  logic              cpu_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   bytes_loaded;

  wr_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;
  bit  use_gaps = 1'b1;

  always #5 clk = ~clk;

  inst_mem_loader #(
    .DEPTH       (DEPTH),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_be        (wr_be),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .err_code     (err_code),
    .bytes_loaded (bytes_loaded)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents is matched against the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (!rst && wr_en) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL wr_unexpected: got write @0x%0h data 0x%08h, expected none", wr_addr, wr_data);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(wr_addr), 32'(e.addr));
        check("wr_data", wr_data, e.data);
        check("wr_be", 32'(wr_be), 32'(e.be));
      end
    end
  end

  // Reference: byte n lands in word n/4, lane n%4; a word closes at lane 3 or the last byte.
  task automatic expect_writes(input bq_t p, input int len);
    logic [31:0] d;
    logic [3:0]  b;
    wr_t         w;
    d = '0;
    b = '0;
    for (int n = 0; n < p.size(); n++) begin
      d[8*(n%4) +: 8] = p[n];
      b[n%4] = 1'b1;
      if ((n % 4 == 3) || (n == len - 1)) begin
        w.addr = ADDR_W'(n - (n % 4));
        w.data = d;
        w.be   = b;
        sb.push_back(w);
        d = '0;
        b = '0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit poke_start);
    bit r;
    r = 1'b0;
    in_valid = 1'b1;
    in_byte  = b;
    start    = poke_start;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      r = in_ready;
      @(posedge clk);
      #1;
      if (r) break;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    if (!r) begin
      n_vec++;
      n_err++;
      $display("FAIL handshake: got in_ready=0 for 50 cycles, expected byte 0x%0h accepted", b);
    end
    if (use_gaps) tick($urandom_range(0, 2));
  endtask

  // Start is issued with the first header byte already valid; it must not be taken in IDLE.
  task automatic start_load(input logic [7:0] first);
    start    = 1'b1;
    in_valid = 1'b1;
    in_byte  = first;
    tick(1);
    start = 1'b0;
    send_byte(first, 1'b0);
  endtask

  task automatic do_load(input int len, input bq_t p, input bit good, input bit poke);
    logic [7:0]  x;
    logic [7:0]  ck;
    logic [15:0] l16;
    bit          bad;
    l16 = 16'(len);
    bad = (len == 0) || (len > DEPTH);
    x = 8'h00;
    foreach (p[i]) x ^= p[i];
    if (!bad) expect_writes(p, len);
    start_load(l16[7:0]);
    send_byte(l16[15:8], 1'b0);
    if (bad) begin
      tick(3);
      check("badlen_err", 32'(err), 1);
      check("badlen_code", 32'(err_code), 1);
      check("badlen_hold", 32'(cpu_hold), 1);
      check("badlen_done", 32'(done), 0);
      check("badlen_sb", sb.size(), 0);
      return;
    end
    for (int i = 0; i < len; i++) send_byte(p[i], poke && (i == 1));
    ck = good ? x : (x ^ 8'($urandom_range(1, 255)));
    send_byte(ck, 1'b0);
    tick(3);
    check("done", 32'(done), 32'(good));
    check("err", 32'(err), 32'(!good));
    check("err_code", 32'(err_code), good ? 0 : 2);
    check("cpu_hold", 32'(cpu_hold), 32'(!good));
    check("bytes_loaded", 32'(bytes_loaded), 32'(len));
    check("sb_drained", sb.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 0);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_err_code"}, 32'(err_code), 0);
    check({tag, "_bytes"}, 32'(bytes_loaded), 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, expected completion before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t p;
    int  k;
    rst = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_byte = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(2);

    p = {8'h93, 8'h00, 8'h00, 8'h0F, 8'h13, 8'h01, 8'h50, 8'h0A};
    do_load(8, p, 1'b1, 1'b0);

    p = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    do_load(5, p, 1'b1, 1'b0);

    p = {};
    do_load(0, p, 1'b1, 1'b0);
    do_load(4097, p, 1'b1, 1'b0);

    // 00^AA^BB^CC^DD is 0x00, so a 0xFF checksum byte is wrong.
    p = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    expect_writes(p, 4);
    start_load(8'h04);
    send_byte(8'h00, 1'b0);
    foreach (p[i]) send_byte(p[i], 1'b0);
    send_byte(8'hFF, 1'b0);
    tick(3);
    check("cks_err", 32'(err), 1);
    check("cks_code", 32'(err_code), 2);
    check("cks_hold", 32'(cpu_hold), 1);
    check("cks_sb", sb.size(), 0);

    // Timeout: four bytes of an 8-byte payload, then silence.
    use_gaps = 1'b0;
    p = {8'h01, 8'h02, 8'h03, 8'h04};
    expect_writes(p, 8);
    start_load(8'h08);
    send_byte(8'h00, 1'b0);
    foreach (p[i]) send_byte(p[i], 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err && k < 100);
    check("to_fired", 32'(err), 1);
    check("to_window", 32'((k >= TO) && (k <= TO + 1)), 1);
    check("to_code", 32'(err_code), 3);
    check("to_hold", 32'(cpu_hold), 1);
    check("to_bytes", 32'(bytes_loaded), 4);
    check("to_sb", sb.size(), 0);
    @(posedge clk);
    #1;
    use_gaps = 1'b1;

    // Reset in the middle of a payload.
    start_load(8'h08);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    tick(1);
    p = {};
    for (int i = 0; i < 12; i++) p.push_back(8'($urandom));
    do_load(12, p, 1'b1, 1'b0);

    for (int t = 0; t < 15; t++) begin
      int len;
      len = $urandom_range(1, 64);
      p = {};
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      do_load(len, p, ($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1) && (len > 2));
    end

    use_gaps = 1'b0;
    p = {};
    for (int i = 0; i < DEPTH; i++) p.push_back(8'($urandom));
    do_load(DEPTH, p, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
